data_sram_like_bridge: RTL and testbench
========================================

// Module: data_sram_like_bridge
// PURPOSE
// - Converts the MEM stage's single-cycle SRAM-style data access (en/wen/addr/wdata/rdata) into the
//   split-handshake SRAM-like data channel (req/addr_ok/data_ok) consumed by the AXI bridge.
// - Sits directly upstream of the AXI interface's data port; stalls the pipeline until the access completes.
// - Holds read data stable while the pipeline is stalled for other reasons.
// PARAMETERS
// - ADDR_W  32  address width
// - DATA_W  32  data width
// PORTS
// - clk              in   1       clock; all state changes on rising edge
// - rst              in   1       reset, asynchronous, active-high
// - data_sram_en     in   1       MEM stage requests a data access this cycle
// - data_sram_wen    in   4       byte write enables; 0 = read, nonzero = write
// - data_sram_size   in   2       0 byte, 1 half, 2 word (from load/store opcode)
// - data_sram_addr   in   ADDR_W  byte address
// - data_sram_wdata  in   DATA_W  write data, already lane-aligned
// - data_sram_rdata  out  DATA_W  read data returned to MEM stage
// - flush            in   1       exception/ERET flush; suppresses an access not yet issued
// - longest_stall    in   1       pipeline held by another source; MEM stage cannot consume this cycle
// - d_stall          out  1       stall request to the hazard unit
// - data_req         out  1       SRAM-like request valid
// - data_wr          out  1       1 = write
// - data_size        out  2       access size
// - data_addr        out  ADDR_W  address
// - data_wdata       out  DATA_W  write data
// - data_rdata       in   DATA_W  read data (valid with data_data_ok)
// - data_addr_ok     in   1       request accepted
// - data_data_ok     in   1       data returned / write completed
// BEHAVIOUR
// - States: IDLE, REQ, WAIT, DONE. Reset (async): IDLE, data_req=0, saved rdata=0, all request regs=0.
// - IDLE: en & ~flush -> latch wr=|wen, size, addr, wdata; next REQ. Otherwise stay.
// - REQ: data_req=1, outputs driven from latched regs (stable until addr_ok).
//   addr_ok & ~data_ok -> WAIT. addr_ok & data_ok same cycle -> complete (see below). No addr_ok -> stay.
//   data_req deasserts the cycle after addr_ok; exactly one request per access.
// - WAIT: data_req=0. data_ok -> complete. data_ok without prior addr_ok never expected (assert).
// - Complete: capture data_rdata into saved_rdata (reads only); next = longest_stall ? DONE : IDLE.
// - DONE: hold saved_rdata; ~longest_stall -> IDLE.
// - data_sram_rdata = data_rdata in the completing cycle, saved_rdata otherwise (zero-bubble release).
// - d_stall = data_sram_en & ~flush & ~(DONE | completing this cycle); asserted combinationally in IDLE
//   the same cycle en rises. Min latency: en at cycle 0, req cycle 1, data_ok cycle 2 -> stall drops cycle 2.
// - flush in REQ/WAIT: transaction runs to completion (AXI cannot abort), result discarded, d_stall=0;
//   FSM returns to IDLE on completion, ignoring longest_stall. New en is not accepted until IDLE.
// - Write: data_wdata passed unchanged; byte strobes derived downstream from size+addr[1:0].
// - Reset mid-transaction: FSM to IDLE immediately; bus-side recovery is the interface's reset responsibility.
// STRUCTURE
// - Shared package cpu_mem_pkg: state enum {IDLE,REQ,WAIT,DONE}; SIZE_BYTE=2'd0, SIZE_HALF=2'd1,
//   SIZE_WORD=2'd2; same package reused by the instruction-side bridge.
// - Single module, no sub-modules; one FSM always block, one request-latch block, combinational outputs.
// TESTING
// - Read word: en=1,wen=0,size=2,addr=0x8000_0010; addr_ok cyc1, data_ok+rdata=0xDEAD_BEEF cyc3
//   -> one req pulse, d_stall high cycles 0-2, low cyc3, rdata=0xDEAD_BEEF cyc3.
// - Byte store: wen=4'b0100,size=0,addr=0x...02,wdata=0x00AB_0000; addr_ok & data_ok same cycle
//   -> data_wr=1,size=0, single req, stall released that cycle, FSM to IDLE.
// - Held read: data_ok arrives with longest_stall=1 for 3 cycles -> DONE, rdata stable 4 cycles
//   despite data_rdata changing, IDLE after stall drops.
// - addr_ok delayed 5 cycles -> req, addr, size, wdata constant throughout; no duplicate request.
// - flush asserted in WAIT -> d_stall=0 immediately, data_ok later absorbed, no second req; next en issued normally.
// - Async reset asserted in REQ mid-cycle -> data_req=0 before next clock edge, state IDLE.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg
// Shared definitions for the instruction- and data-side SRAM-to-SRAM-like
// bridges: the bridge FSM state encoding and the access-size codes carried
// on the *_size buses.
package cpu_mem_pkg;

    // Bridge FSM states.
    //   IDLE : no access outstanding
    //   REQ  : request presented on the bus, waiting for addr_ok
    //   WAIT : address accepted, waiting for data_ok
    //   DONE : access finished while the pipeline was held; result parked
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    // Access size codes (from the load/store opcode).
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/data_sram_like_bridge.sv
// data_sram_like_bridge
// Turns the MEM stage's single-cycle SRAM-style data access into one
// split-handshake SRAM-like transaction (req / addr_ok / data_ok) and stalls
// the pipeline until it finishes. Read data is parked so it stays stable
// while the pipeline is held by another stall source.
//
// Handshake: a request is transferred on the rising edge where data_req and
// data_addr_ok are both high; data_req, data_wr, data_size, data_addr and
// data_wdata hold steady from the first cycle data_req is high until that
// edge. data_data_ok (with data_rdata for reads) marks completion and is
// only legal once the address has been accepted (same cycle or later).
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   data_sram_*       MEM-stage SRAM-style port (en, wen, size, addr, wdata in; rdata out)
//   flush             exception/ERET flush; kills an access not yet issued
//   longest_stall     pipeline held by another source this cycle
//   d_stall           stall request to the hazard unit
//   data_req .. data_wdata   SRAM-like request channel (out)
//   data_rdata, data_addr_ok, data_data_ok   SRAM-like response channel (in)
//   fsm_state         current FSM state (debug / observation)
module data_sram_like_bridge
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_sram_en,
    input  logic [3:0]        data_sram_wen,
    input  logic [1:0]        data_sram_size,
    input  logic [ADDR_W-1:0] data_sram_addr,
    input  logic [DATA_W-1:0] data_sram_wdata,
    output logic [DATA_W-1:0] data_sram_rdata,
    input  logic              flush,
    input  logic              longest_stall,
    output logic              d_stall,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic [DATA_W-1:0] data_rdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    output logic [1:0]        fsm_state
);

    mem_state_t        state;
    mem_state_t        state_next;

    logic              req_wr;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0] saved_rdata;
    // Set once a flush hits an issued access; the bus transaction still has
    // to finish, but its result is thrown away.
    logic              flushed;

    logic              completing;
    logic              discard;
    logic              deliver;
    logic              accept;

    // The access finishes this cycle: either both handshakes coincide in REQ,
    // or data_ok arrives in WAIT.
    assign completing = ((state == REQ) && data_addr_ok && data_data_ok) ||
                        ((state == WAIT) && data_data_ok);
    assign discard    = flushed || flush;
    assign deliver    = completing && !discard;
    assign accept     = (state == IDLE) && data_sram_en && !flush;

    // ---------------- FSM ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = REQ;
            end
            REQ: begin
                if (data_addr_ok) begin
                    if (data_data_ok)
                        state_next = (longest_stall && !discard) ? DONE : IDLE;
                    else
                        state_next = WAIT;
                end
            end
            WAIT: begin
                if (data_data_ok)
                    state_next = (longest_stall && !discard) ? DONE : IDLE;
            end
            DONE: begin
                if (!longest_stall) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            flushed     <= 1'b0;
            saved_rdata <= '0;
        end else begin
            state <= state_next;
            if (((state == REQ) || (state == WAIT)) && !completing)
                flushed <= flushed || flush;
            else
                flushed <= 1'b0;
            if (deliver && !req_wr)
                saved_rdata <= data_rdata;
        end
    end

    // ---------------- request latch ----------------
    // Captured once when the access is accepted so the bus sees stable
    // values no matter what the MEM stage drives afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_wr    <= 1'b0;
            req_size  <= SIZE_BYTE;
            req_addr  <= '0;
            req_wdata <= '0;
        end else if (accept) begin
            req_wr    <= |data_sram_wen;
            req_size  <= data_sram_size;
            req_addr  <= data_sram_addr;
            req_wdata <= data_sram_wdata;
        end
    end

    // ---------------- outputs ----------------
    assign data_req   = (state == REQ);
    assign data_wr    = req_wr;
    assign data_size  = req_size;
    assign data_addr  = req_addr;
    assign data_wdata = req_wdata;
    assign fsm_state  = state;

    // Forward bus data in the completing cycle so the stall can drop with no
    // bubble; afterwards the parked copy is shown.
    assign data_sram_rdata = deliver ? data_rdata : saved_rdata;

    // Stall while an access is wanted and its result is not yet available.
    // A discarded completion does not release a newer access waiting in IDLE.
    assign d_stall = data_sram_en && !flush && !((state == DONE) || deliver);

    // data_ok is only legal once the address has been accepted.
    a_data_ok_after_addr_ok : assert property (
        @(posedge clk) disable iff (rst)
        data_data_ok |-> ((state == WAIT) || ((state == REQ) && data_addr_ok))
    );

endmodule

// File: tb/tb_data_sram_like_bridge.sv
module tb_data_sram_like_bridge;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic              clk;
    logic              rst;
    logic              data_sram_en;
    logic [3:0]        data_sram_wen;
    logic [1:0]        data_sram_size;
    logic [ADDR_W-1:0] data_sram_addr;
    logic [DATA_W-1:0] data_sram_wdata;
    logic [DATA_W-1:0] data_sram_rdata;
    logic              flush;
    logic              longest_stall;
    logic              d_stall;
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic [DATA_W-1:0] data_rdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [1:0]        fsm_state;

    int errors = 0;
    int checks = 0;
    int hs_count = 0;
    logic [DATA_W-1:0] exp_q[$];

    data_sram_like_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_size  (data_sram_size),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .flush           (flush),
        .longest_stall   (longest_stall),
        .d_stall         (d_stall),
        .data_req        (data_req),
        .data_wr         (data_wr),
        .data_size       (data_size),
        .data_addr       (data_addr),
        .data_wdata      (data_wdata),
        .data_rdata      (data_rdata),
        .data_addr_ok    (data_addr_ok),
        .data_data_ok    (data_data_ok),
        .fsm_state       (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepted requests (req & addr_ok on a rising edge).
    always @(posedge clk) begin
        if (!rst && data_req && data_addr_ok) hs_count = hs_count + 1;
    end

    // ---------------- driver tasks ----------------
    // Advance to the next cycle; inputs are driven 1 time unit after the edge
    // and checks happen 2 more units later, well before the next edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic bus_idle();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = '0;
    endtask

    task automatic mem_access(input logic [3:0] wen, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata);
        data_sram_en    = 1'b1;
        data_sram_wen   = wen;
        data_sram_size  = size;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        data_sram_en = 1'b0; data_sram_wen = '0; data_sram_size = '0;
        data_sram_addr = '0; data_sram_wdata = '0;
        flush = 1'b0; longest_stall = 1'b0;
        bus_idle();
        repeat (3) next_cycle();
        settle();
        checks++; if (fsm_state !== S_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", fsm_state, S_IDLE); end
        checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", data_req); end
        checks++; if (data_sram_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", data_sram_rdata); end
        checks++; if ({data_wr, data_size, data_addr, data_wdata} !== 67'h0) begin errors++; $display("FAIL reset_req_regs got wr=%b size=%0d addr=%h wdata=%h exp all zero", data_wr, data_size, data_addr, data_wdata); end
        checks++; if (d_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", d_stall); end
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_read_word();
        logic [31:0] exp_d;
        int hs0;
        hs0 = hs_count;
        exp_q.push_back(32'hDEAD_BEEF);
        // cycle 0
        mem_access(4'b0000, 2'd2, 32'h8000_0010, 32'h0);
        settle();
        checks++; if ({d_stall, data_req} !== 2'b10) begin errors++; $display("FAIL rd_c0 got stall=%b req=%b exp stall=1 req=0", d_stall, data_req); end
        // cycle 1
        next_cycle(); data_addr_ok = 1'b1; settle();
        checks++; if ({data_req, data_wr, data_size, data_addr, d_stall} !== {1'b1, 1'b0, 2'd2, 32'h8000_0010, 1'b1}) begin
            errors++; $display("FAIL rd_c1 got req=%b wr=%b size=%0d addr=%h stall=%b exp 1 0 2 80000010 1", data_req, data_wr, data_size, data_addr, d_stall); end
        // cycle 2
        next_cycle(); data_addr_ok = 1'b0; settle();
        checks++; if ({data_req, d_stall} !== 2'b01) begin errors++; $display("FAIL rd_c2 got req=%b stall=%b exp req=0 stall=1", data_req, d_stall); end
        // cycle 3
        next_cycle(); data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF; settle();
        exp_d = exp_q.pop_front();
        checks++; if (d_stall !== 1'b0 || data_sram_rdata !== exp_d) begin errors++; $display("FAIL rd_c3 got stall=%b rdata=%h exp stall=0 rdata=%h", d_stall, data_sram_rdata, exp_d); end
        // cycle 4
        next_cycle(); data_sram_en = 1'b0; bus_idle(); settle();
        checks++; if (fsm_state !== S_IDLE || data_sram_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_c4 got state=%0d rdata=%h exp state=0 rdata=deadbeef", fsm_state, data_sram_rdata); end
        checks++; if (hs_count - hs0 !== 1) begin errors++; $display("FAIL rd_req_count got=%0d exp=1", hs_count - hs0); end
    endtask

    task automatic test_byte_store();
        int hs0;
        hs0 = hs_count;
        mem_access(4'b0100, 2'd0, 32'h8000_0002, 32'h00AB_0000);
        next_cycle(); data_addr_ok = 1'b1; data_data_ok = 1'b1; settle();
        checks++; if ({data_req, data_wr, data_size, data_addr, data_wdata, d_stall} !== {1'b1, 1'b1, 2'd0, 32'h8000_0002, 32'h00AB_0000, 1'b0}) begin
            errors++; $display("FAIL st_c1 got req=%b wr=%b size=%0d addr=%h wdata=%h stall=%b exp 1 1 0 80000002 00ab0000 0", data_req, data_wr, data_size, data_addr, data_wdata, d_stall); end
        next_cycle(); data_sram_en = 1'b0; bus_idle(); settle();
        checks++; if (fsm_state !== S_IDLE || data_req !== 1'b0) begin errors++; $display("FAIL st_c2 got state=%0d req=%b exp state=0 req=0", fsm_state, data_req); end
        checks++; if (hs_count - hs0 !== 1) begin errors++; $display("FAIL st_req_count got=%0d exp=1", hs_count - hs0); end
    endtask

    task automatic test_held_read();
        logic [31:0] noise [3];
        noise[0] = 32'hFFFF_0000; noise[1] = 32'h5555_AAAA; noise[2] = 32'h0F0F_0F0F;
        mem_access(4'b0000, 2'd2, 32'h0000_0100, 32'h0);
        next_cycle(); data_addr_ok = 1'b1;
        // cycle 2: completion while the pipeline is held
        next_cycle(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1234_5678; longest_stall = 1'b1; settle();
        checks++; if (d_stall !== 1'b0 || data_sram_rdata !== 32'h1234_5678) begin errors++; $display("FAIL hold_c2 got stall=%b rdata=%h exp 0 12345678", d_stall, data_sram_rdata); end
        // cycles 3..5: DONE, bus data changes, parked value must not
        for (int i = 0; i < 3; i++) begin
            next_cycle(); data_data_ok = 1'b0; data_rdata = noise[i];
            longest_stall = (i < 2); settle();
            checks++; if (fsm_state !== S_DONE || data_sram_rdata !== 32'h1234_5678 || d_stall !== 1'b0) begin
                errors++; $display("FAIL hold_c%0d got state=%0d rdata=%h stall=%b exp 3 12345678 0", i + 3, fsm_state, data_sram_rdata, d_stall); end
        end
        next_cycle(); data_sram_en = 1'b0; longest_stall = 1'b0; bus_idle(); settle();
        checks++; if (fsm_state !== S_IDLE) begin errors++; $display("FAIL hold_release got state=%0d exp=0", fsm_state); end
    endtask

    task automatic test_delayed_addr_ok();
        int hs0;
        hs0 = hs_count;
        mem_access(4'b1111, 2'd2, 32'h8000_0040, 32'hCAFE_F00D);
        for (int i = 1; i <= 5; i++) begin
            next_cycle();
            // Upstream garbage must not reach the bus once latched.
            data_sram_addr = 32'h1111_1111 * i; data_sram_wdata = 32'h2222_2222 * i; data_sram_size = 2'd1;
            settle();
            checks++; if ({data_req, data_wr, data_size, data_addr, data_wdata, d_stall} !== {1'b1, 1'b1, 2'd2, 32'h8000_0040, 32'hCAFE_F00D, 1'b1}) begin
                errors++; $display("FAIL dly_c%0d got req=%b wr=%b size=%0d addr=%h wdata=%h stall=%b exp 1 1 2 80000040 cafef00d 1", i, data_req, data_wr, data_size, data_addr, data_wdata, d_stall); end
        end
        next_cycle(); data_addr_ok = 1'b1;
        next_cycle(); data_addr_ok = 1'b0; settle();
        checks++; if (data_req !== 1'b0 || d_stall !== 1'b1) begin errors++; $display("FAIL dly_wait got req=%b stall=%b exp 0 1", data_req, d_stall); end
        next_cycle(); data_data_ok = 1'b1; settle();
        checks++; if (d_stall !== 1'b0) begin errors++; $display("FAIL dly_done got stall=%b exp 0", d_stall); end
        next_cycle(); data_sram_en = 1'b0; bus_idle(); settle();
        checks++; if (hs_count - hs0 !== 1) begin errors++; $display("FAIL dly_req_count got=%0d exp=1", hs_count - hs0); end
    endtask

    task automatic test_flush_wait();
        int hs0;
        hs0 = hs_count;
        mem_access(4'b0000, 2'd2, 32'h0000_0200, 32'h0);
        next_cycle(); data_addr_ok = 1'b1;
        next_cycle(); data_addr_ok = 1'b0; flush = 1'b1; settle();
        checks++; if (d_stall !== 1'b0) begin errors++; $display("FAIL fl_stall got=%b exp=0", d_stall); end
        next_cycle(); flush = 1'b0; data_sram_en = 1'b0; settle();
        checks++; if (fsm_state !== S_WAIT || d_stall !== 1'b0) begin errors++; $display("FAIL fl_waiting got state=%0d stall=%b exp 2 0", fsm_state, d_stall); end
        // New access arrives while the flushed one is still in flight.
        next_cycle(); mem_access(4'b0000, 2'd2, 32'h0000_0300, 32'h0); settle();
        checks++; if (d_stall !== 1'b1 || data_req !== 1'b0) begin errors++; $display("FAIL fl_new_blocked got stall=%b req=%b exp 1 0", d_stall, data_req); end
        next_cycle(); data_data_ok = 1'b1; data_rdata = 32'hBAD0_BAD0; longest_stall = 1'b1; settle();
        checks++; if (d_stall !== 1'b1 || data_sram_rdata !== 32'h1234_5678) begin errors++; $display("FAIL fl_absorb got stall=%b rdata=%h exp 1 12345678", d_stall, data_sram_rdata); end
        next_cycle(); bus_idle(); longest_stall = 1'b0; settle();
        checks++; if (fsm_state !== S_IDLE || d_stall !== 1'b1) begin errors++; $display("FAIL fl_idle got state=%0d stall=%b exp 0 1", fsm_state, d_stall); end
        next_cycle(); data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h0BAD_F00D; settle();
        checks++; if (data_req !== 1'b1 || data_addr !== 32'h0000_0300 || d_stall !== 1'b0 || data_sram_rdata !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL fl_next got req=%b addr=%h stall=%b rdata=%h exp 1 00000300 0 0badf00d", data_req, data_addr, d_stall, data_sram_rdata); end
        next_cycle(); data_sram_en = 1'b0; bus_idle(); settle();
        checks++; if (hs_count - hs0 !== 2) begin errors++; $display("FAIL fl_req_count got=%0d exp=2", hs_count - hs0); end
    endtask

    task automatic test_async_reset();
        mem_access(4'b0000, 2'd1, 32'h0000_0402, 32'h0);
        next_cycle(); settle();
        checks++; if (data_req !== 1'b1) begin errors++; $display("FAIL ar_pre got req=%b exp=1", data_req); end
        #1 rst = 1'b1;
        #1;
        checks++; if (data_req !== 1'b0 || fsm_state !== S_IDLE || data_sram_rdata !== 32'h0) begin
            errors++; $display("FAIL ar_mid got req=%b state=%0d rdata=%h exp 0 0 0", data_req, fsm_state, data_sram_rdata); end
        data_sram_en = 1'b0;
        next_cycle(); rst = 1'b0;
        next_cycle(); settle();
        checks++; if (fsm_state !== S_IDLE || data_req !== 1'b0) begin errors++; $display("FAIL ar_post got state=%0d req=%b exp 0 0", fsm_state, data_req); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_read_word();
        test_byte_store();
        test_held_read();
        test_delayed_addr_ok();
        test_flush_wait();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog: the directed sequence is short; never let a run hang.
    initial begin
        #20000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
